// File: rtl/ram_pkg.sv
// Shared types and helpers for the 1-write / N-read self-clearing RAM.
package ram_pkg;

  localparam int MAX_W = 256;
  localparam int MAX_L = 32;

  typedef enum logic {CLEAR, READY} ram_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Lanes of width lane_w whose mask bit is set take nw; others keep old.
  function automatic logic [MAX_W-1:0] lane_merge(input logic [MAX_W-1:0] old,
                                                  input logic [MAX_W-1:0] nw,
                                                  input logic [MAX_L-1:0] mask,
                                                  input int lane_w);
    logic [MAX_W-1:0] r;
    r = old;
    for (int b = 0; b < MAX_W; b++) begin
      if ((b / lane_w) < MAX_L && mask[b / lane_w]) r[b] = nw[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_1w_1rs_bank.sv
// One storage array with a masked write port and one registered read port;
// zero-forcing and write forwarding are selected by the top.
module ram_1w_1rs_bank
  import ram_pkg::*;
#(
  parameter int wordCount = 64,
  parameter int wordWidth = 32,
  parameter int maskWidth = 4,
  parameter int addrWidth = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [addrWidth-1:0] waddr,
  input  logic [wordWidth-1:0] wdata,
  input  logic [maskWidth-1:0] wmask,
  input  logic                 re,
  input  logic [addrWidth-1:0] raddr,
  input  logic                 rzero,
  input  logic                 fwd,
  output logic [wordWidth-1:0] rdata
);

  localparam int LANE_W = wordWidth / maskWidth;

  logic [wordWidth-1:0] mem [wordCount];
  logic [wordWidth-1:0] rdata_q;
  logic [wordWidth-1:0] rdata_d;
  logic [wordWidth-1:0] old_word;

  function automatic logic [wordWidth-1:0] merge(input logic [wordWidth-1:0] o,
                                                 input logic [wordWidth-1:0] n,
                                                 input logic [maskWidth-1:0] m);
    return wordWidth'(lane_merge(MAX_W'(o), MAX_W'(n), MAX_L'(m), LANE_W));
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merge(mem[waddr], wdata, wmask);
  end

  assign old_word = mem[raddr];

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (rzero)    rdata_d = '0;
      else if (fwd) rdata_d = merge(old_word, wdata, wmask);
      else          rdata_d = old_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/ram_1w_nrs_clear.sv
// Single-write, N-read RAM that zeroes itself after reset or on clear.
// Define RAM_1W_NRS_BYPASS_EN for write-first same-address behaviour.
module ram_1w_nrs_clear
  import ram_pkg::*;
#(
  parameter int   wordCount = 64,
  parameter int   wordWidth = 32,
  parameter int   maskWidth = 4,
  parameter int   readPorts = 2,
  localparam int  addrWidth = clog2(wordCount)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           clear,
  output logic                           busy,
  input  logic                           wr_en,
  input  logic [maskWidth-1:0]           wr_mask,
  input  logic [addrWidth-1:0]           wr_addr,
  input  logic [wordWidth-1:0]           wr_data,
  input  logic [readPorts-1:0]           rd_en,
  input  logic [readPorts*addrWidth-1:0] rd_addr,
  output logic [readPorts*wordWidth-1:0] rd_data,
  output logic [readPorts-1:0]           rd_valid
);

  localparam logic [addrWidth:0]   WORDS = (addrWidth+1)'(wordCount);
  localparam logic [addrWidth-1:0] LAST  = addrWidth'(wordCount - 1);

  ram_state_e           state_q, state_d;
  logic [addrWidth-1:0] cnt_q, cnt_d;
  logic [readPorts-1:0] rd_valid_q, rd_valid_d;
  logic                 ready;
  logic                 wr_ok;
  logic                 bank_we;
  logic [addrWidth-1:0] bank_waddr;
  logic [wordWidth-1:0] bank_wdata;
  logic [maskWidth-1:0] bank_wmask;

  assign ready = (state_q == READY);
  assign busy  = (state_q == CLEAR);
  // clear has priority over a same-cycle write
  assign wr_ok = ready && wr_en && !clear && ({1'b0, wr_addr} < WORDS);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        state_d = READY;
        cnt_d   = '0;
      end
    end else if (clear) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // The sweep shares the bank write port with user writes.
  assign bank_we    = busy || wr_ok;
  assign bank_waddr = busy ? cnt_q : wr_addr;
  assign bank_wdata = busy ? '0 : wr_data;
  assign bank_wmask = busy ? '1 : wr_mask;

  assign rd_valid_d = ready ? rd_en : '0;
  assign rd_valid   = rd_valid_q;

  for (genvar p = 0; p < readPorts; p++) begin : g_port
    logic [addrWidth-1:0] raddr;
    logic                 rzero;
    logic                 fwd;

    assign raddr = rd_addr[p*addrWidth +: addrWidth];
    assign rzero = !({1'b0, raddr} < WORDS);
`ifdef RAM_1W_NRS_BYPASS_EN
    assign fwd = wr_ok && (raddr == wr_addr);
`else
    assign fwd = 1'b0;
`endif

    ram_1w_1rs_bank #(
      .wordCount(wordCount),
      .wordWidth(wordWidth),
      .maskWidth(maskWidth),
      .addrWidth(addrWidth)
    ) u_bank (
      .clk  (clk),
      .reset(reset),
      .we   (bank_we),
      .waddr(bank_waddr),
      .wdata(bank_wdata),
      .wmask(bank_wmask),
      .re   (rd_valid_d[p]),
      .raddr(raddr),
      .rzero(rzero),
      .fwd  (fwd),
      .rdata(rd_data[p*wordWidth +: wordWidth])
    );
  end

endmodule
